// File: rtl/jt12_mmr_q.sv
// Queued CPU write front-end: applies global registers locally and forwards channel/operator writes over valid/ready.
// Optional JT12_PCM_BYPASS_EN: bank-0 writes to 0x2A update pcm[8:1] directly, without queueing.
module jt12_mmr_q #(
  parameter int CH_BANKS = 2,
  parameter int DEPTH    = 4,
  localparam int BW = $clog2(CH_BANKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic          clk_en,
  input  logic [7:0]    din,
  input  logic [BW:0]   addr,
  input  logic          write,
  output logic          busy,
  output logic          ovf,
  output logic          lfo_en,
  output logic [2:0]    lfo_freq,
  output logic [9:0]    value_A,
  output logic [7:0]    value_B,
  output logic          load_A,
  output logic          load_B,
  output logic          enable_irq_A,
  output logic          enable_irq_B,
  output logic          clr_flag_A,
  output logic          clr_flag_B,
  output logic          fast_timers,
  output logic          csm,
  output logic          effect,
  output logic          eg_stop,
  output logic          pg_stop,
  output logic          pcm_en,
  output logic [8:0]    pcm,
  output logic          up_valid,
  input  logic          up_ready,
  output logic [7:0]    up_reg,
  output logic [BW+1:0] up_ch,
  output logic [1:0]    up_op,
  output logic [7:0]    up_din
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = BW + 16;

  logic          write_q, stb, addr_stb, data_stb, push, pop, full, empty, bypass;
  logic [7:0]    sel_reg;
  logic [BW-1:0] sel_bank;
  logic [2:0]    cnt, lim;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [BW-1:0] e_bank;
  logic [7:0]    e_reg, e_dat;
  logic          fwd;
  logic [BW+1:0] fwd_ch;

  assign stb      = write & ~write_q;
  assign addr_stb = stb & ~addr[0];
  assign data_stb = stb & addr[0];
`ifdef JT12_PCM_BYPASS_EN
  assign bypass = data_stb && sel_reg == 8'h2A && sel_bank == '0;
`else
  assign bypass = 1'b0;
`endif
  assign push  = data_stb & ~bypass;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = clk_en & ~empty & ~(up_valid & ~up_ready);
  assign busy  = ~empty | up_valid | push;

  assign {e_bank, e_reg, e_dat} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && (!full || pop))
      mem[wr_ptr] <= {sel_bank, sel_reg, din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && (!full || pop)) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push && (!full || pop), pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // 0x28 key-on keeps the upper bank bits but takes the low bank bit from d2
  always_comb begin
    fwd    = 1'b0;
    fwd_ch = '0;
    if (e_reg == 8'h28) begin
      fwd       = (e_dat[1:0] != 2'd3);
      fwd_ch    = {e_bank, e_dat[1:0]};
      fwd_ch[2] = e_dat[2];
    end else if (e_reg >= 8'h30) begin
      fwd    = (e_reg[1:0] != 2'd3) && (e_reg < 8'hB8);
      fwd_ch = {e_bank, e_reg[1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      clk_en <= 1'b0;
    end else begin
      clk_en <= cen && (cnt == lim);
      if (cen) cnt <= (cnt == lim) ? 3'd0 : cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;   sel_reg <= '0;      sel_bank <= '0;
      lim <= 3'd5;       ovf <= 1'b0;
      lfo_en <= 1'b0;    lfo_freq <= '0;     value_A <= '0;      value_B <= '0;
      load_A <= 1'b0;    load_B <= 1'b0;     enable_irq_A <= 1'b0; enable_irq_B <= 1'b0;
      clr_flag_A <= 1'b0; clr_flag_B <= 1'b0; fast_timers <= 1'b0;
      csm <= 1'b0;       effect <= 1'b0;     eg_stop <= 1'b0;    pg_stop <= 1'b0;
      pcm_en <= 1'b0;    pcm <= '0;
      up_valid <= 1'b0;  up_reg <= '0;       up_ch <= '0;        up_op <= '0;  up_din <= '0;
    end else begin
      write_q <= write;
      if (addr_stb) begin
        sel_reg  <= din;
        sel_bank <= addr[BW:1];
      end
      if (push && full && !pop) ovf <= 1'b1;
      if (clk_en) {clr_flag_B, clr_flag_A} <= 2'b00;
      if (up_valid && up_ready) up_valid <= 1'b0;
      if (pop) begin
        case (e_reg)
          8'h21: {eg_stop, pg_stop, fast_timers} <= {e_dat[5], e_dat[3], e_dat[2]};
          8'h22: {lfo_en, lfo_freq} <= e_dat[3:0];
          8'h24: value_A[9:2] <= e_dat;
          8'h25: value_A[1:0] <= e_dat[1:0];
          8'h26: value_B <= e_dat;
          8'h27: begin
            effect <= |e_dat[7:6];
            csm    <= (e_dat[7:6] == 2'b10);
            {clr_flag_B, clr_flag_A, enable_irq_B, enable_irq_A, load_B, load_A} <= e_dat[5:0];
          end
          8'h2A: pcm[8:1] <= e_dat;
          8'h2B: pcm_en <= e_dat[7];
          8'h2C: pcm[0] <= e_dat[3];
          8'h2D: lim <= 3'd5;
          8'h2E: lim <= 3'd2;
          8'h2F: lim <= 3'd1;
          default: ;
        endcase
        if (fwd) begin
          up_valid <= 1'b1;
          up_reg   <= e_reg;
          up_ch    <= fwd_ch;
          up_op    <= e_reg[3:2];
          up_din   <= e_dat;
        end
      end
`ifdef JT12_PCM_BYPASS_EN
      if (bypass) pcm[8:1] <= din;
`endif
    end
  end
endmodule

// File: tb/tb_jt12_mmr_q.sv
// Scoreboarded bench for jt12_mmr_q (CH_BANKS=4, DEPTH=4); expectations follow JT12_PCM_BYPASS_EN when defined.
module tb_jt12_mmr_q;
  logic       clk, rst, cen, write, up_ready;
  logic [2:0] addr;
  logic [7:0] din;
  logic       clk_en, busy, ovf, lfo_en, load_A, load_B, enable_irq_A, enable_irq_B;
  logic       clr_flag_A, clr_flag_B, fast_timers, csm, effect, eg_stop, pg_stop, pcm_en, up_valid;
  logic [2:0] lfo_freq;
  logic [9:0] value_A;
  logic [7:0] value_B, up_reg, up_din;
  logic [8:0] pcm;
  logic [3:0] up_ch;
  logic [1:0] up_op;

  typedef struct packed {
    logic [3:0] ch;
    logic [1:0] op;
    logic [7:0] r;
    logic [7:0] d;
  } fwd_t;
  fwd_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic ce;

  jt12_mmr_q #(.CH_BANKS(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cen(cen), .clk_en(clk_en), .din(din), .addr(addr),
    .write(write), .busy(busy), .ovf(ovf), .lfo_en(lfo_en), .lfo_freq(lfo_freq),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .fast_timers(fast_timers),
    .csm(csm), .effect(effect), .eg_stop(eg_stop), .pg_stop(pg_stop), .pcm_en(pcm_en),
    .pcm(pcm), .up_valid(up_valid), .up_ready(up_ready), .up_reg(up_reg),
    .up_ch(up_ch), .up_op(up_op), .up_din(up_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each accepted forward is compared against the oldest expectation
  always @(negedge clk) begin
    if (!rst && up_valid && up_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fwd_unexpected: got ch=%0h op=%0h reg=%0h din=%0h, expected none",
                 up_ch, up_op, up_reg, up_din);
      end else begin
        check("fwd", {up_ch, up_op, up_reg, up_din}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cen_pulse(output logic c);
    cen = 1'b1;
    tick();
    c = clk_en;
    cen = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a; din = d; write = 1'b1;
    tick();
    write = 1'b0;
    tick();
  endtask

  task automatic areg(input logic [1:0] bank, input logic [7:0] r);
    wr({bank, 1'b0}, r);
  endtask

  task automatic dreg(input logic [1:0] bank, input logic [7:0] d);
    wr({bank, 1'b1}, d);
  endtask

  task automatic expect_fwd(input logic [3:0] ch, input logic [1:0] op, input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back('{ch: ch, op: op, r: r, d: d});
  endtask

  task automatic drain();
    logic c;
    for (int i = 0; i < 64 && busy; i++) cen_pulse(c);
    check("drain_idle", busy, 0);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; write = 1'b0; addr = '0; din = '0; up_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {clk_en, busy, ovf, up_valid}, 0);
    check("rst_glob", {lfo_en, lfo_freq, value_A, value_B, load_A, load_B, enable_irq_A,
                       enable_irq_B, clr_flag_A, clr_flag_B, fast_timers, csm, effect,
                       eg_stop, pg_stop, pcm_en}, 0);
    check("rst_pcm_up", {pcm, up_reg, up_ch, up_op, up_din}, 0);
    rst = 1'b0;
    tick();

    // Prescaler at reset: clk_en after the 6th cen only
    for (int i = 1; i <= 6; i++) begin
      cen_pulse(ce);
      check($sformatf("pre6_pulse%0d", i), ce, (i == 6));
    end

    // 0x2F -> divide by 2
    areg(0, 8'h2F);
    dreg(0, 8'h00);
    check("busy_2f", busy, 1);
    for (int i = 0; i < 6; i++) cen_pulse(ce);
    check("pop_2f_clk_en", ce, 1);
    for (int i = 1; i <= 4; i++) begin
      cen_pulse(ce);
      check($sformatf("pre2_pulse%0d", i), ce, (i % 2 == 0));
    end

    // Timer A split write
    areg(0, 8'h24);
    dreg(0, 8'hAB);
    check("busy_after_strobe", busy, 1);
    areg(0, 8'h25);
    dreg(0, 8'h03);
    drain();
    check("value_A", value_A, 10'h2AF);

    // 0x27: flags set, clear flags self-clear on the next clk_en
    areg(0, 8'h27);
    dreg(0, 8'hBF);
    drain();
    check("r27_fields", {effect, csm, clr_flag_B, clr_flag_A, enable_irq_B, enable_irq_A, load_B, load_A}, 8'hFF);
    cen_pulse(ce);
    cen_pulse(ce);
    check("r27_clr_auto", {clr_flag_B, clr_flag_A, load_B, load_A}, 4'b0011);

    areg(0, 8'h22);
    dreg(0, 8'h0D);
    drain();
    check("lfo", {lfo_en, lfo_freq}, 4'hD);

    // Full queue, then PCM high byte
    areg(0, 8'hA0);
    for (int i = 0; i < 4; i++) begin
      dreg(0, 8'h11 + 8'(i));
      expect_fwd(4'h0, 2'd0, 8'hA0, 8'h11 + 8'(i));
    end
    areg(0, 8'h2A);
    dreg(0, 8'h80);
`ifdef JT12_PCM_BYPASS_EN
    check("pcm_bypass", pcm, 9'h100);
    check("ovf_bypass", ovf, 0);
    drain();
    check("pcm_after_drain", pcm, 9'h100);
`else
    check("pcm_dropped", pcm, 9'h000);
    check("ovf_full_2a", ovf, 1);
    drain();
    check("pcm_after_drain", pcm, 9'h000);
`endif

    // Overflow with back-pressure: 4 of 6 kept
    up_ready = 1'b0;
    areg(0, 8'hA0);
    for (int i = 1; i <= 6; i++) dreg(0, 8'(i));
    for (int i = 1; i <= 4; i++) expect_fwd(4'h0, 2'd0, 8'hA0, 8'(i));
    check("ovf_set", ovf, 1);
    for (int i = 0; i < 6; i++) cen_pulse(ce);
    check("stall_valid", {up_valid, up_din}, {1'b1, 8'h01});
    up_ready = 1'b1;
    drain();

    // Bank 3 operator write, discarded slot 3 and 0xB8
    areg(3, 8'h44);
    dreg(3, 8'h7F);
    expect_fwd(4'hC, 2'd1, 8'h44, 8'h7F);
    areg(3, 8'h43);
    dreg(3, 8'h11);
    areg(1, 8'hB8);
    dreg(1, 8'h22);
    drain();

    // Key-on channel mapping
    areg(1, 8'h28);
    dreg(1, 8'hF6);
    expect_fwd(4'b0110, 2'd2, 8'h28, 8'hF6);
    dreg(1, 8'h03);
    areg(3, 8'h28);
    dreg(3, 8'h01);
    expect_fwd(4'b1001, 2'd2, 8'h28, 8'h01);
    drain();
    check("sb_empty", exp_q.size(), 0);

    // Asynchronous reset with a forward pending
    up_ready = 1'b0;
    areg(0, 8'h30);
    dreg(0, 8'h55);
    cen_pulse(ce);
    cen_pulse(ce);
    check("pending_valid", up_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", {up_valid, busy, ovf, 10'(value_A)}, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jt12_mmr_q.md
# jt12_mmr_q

Parametrised write front-end for the FM core: captures CPU address/data port writes into a DEPTH-entry queue, drains one entry per internal clock-enable, applies global registers (timers, LFO, PCM, test, prescaler) locally and forwards channel/operator writes to the register file over a valid/ready port. Generalises the two-bank, single-write-in-flight interface to CH_BANKS banks of three channels with queued writes, back-pressure and overflow reporting. Sits between the CPU bus glue and the register file/timers.

## Interface
- CH_BANKS, 2: channel banks of 3 channels each; power of two, 2..4. BW = clog2(CH_BANKS).
- DEPTH, 4: write queue depth; power of two, 2..16.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; asynchronous and active-high.
- cen  in  1  input clock enable (chip master clock rate).
- clk_en  out  1  divided enable; reset 0.
- din  in  8  CPU data.
- addr  in  BW+1  addr[0]: 0 = address port, 1 = data port; addr[BW:1] = bank.
- write  in  1  CPU write level; rising edge is one write.
- busy  out  1  reset 0.
- ovf  out  1  sticky queue-overflow flag; reset 0.
- lfo_en, lfo_freq[2:0], value_A[9:0], value_B[7:0], load_A, load_B, enable_irq_A, enable_irq_B, clr_flag_A, clr_flag_B, fast_timers, csm, effect, eg_stop, pg_stop, pcm_en  out  global register fields; reset 0.
- pcm  out  9  DAC sample; reset 0.
- up_valid  out  1  forwarded write pending; reset 0.
- up_ready  in  1  register file accepts forwarded write.
- up_reg  out  8  register number; reset 0.
- up_ch  out  BW+2  {bank, ch[1:0]}; reset 0.
- up_op  out  2  din[3:2] of address write (0=S1,1=S3,2=S2,3=S4); reset 0.
- up_din  out  8  data; reset 0.

## Operation
- Edge detect: write sampled each clk; write strobe = write & ~write_q.
- Address strobe: latch sel_reg = din, sel_bank = addr[BW:1]. Not queued.
- Data strobe: push {sel_bank, sel_reg, din}. Queue full and no pop this cycle: entry dropped, ovf set (cleared only by rst).
- Pop: on clk cycle with clk_en=1, queue non-empty, and not (up_valid & ~up_ready). One entry per clk_en.
- Popped entry, reg < 0x30 (bank ignored except 0x28): 0x21 eg_stop=d5, pg_stop=d3, fast_timers=d2; 0x22 {lfo_en,lfo_freq}=d[3:0]; 0x24 value_A[9:2]; 0x25 value_A[1:0]; 0x26 value_B; 0x27 effect=|d[7:6], csm=(d[7:6]==2), {clr_flag_B,clr_flag_A,enable_irq_B,enable_irq_A,load_B,load_A}=d[5:0]; 0x2A pcm[8:1]; 0x2B pcm_en=d7; 0x2C pcm[0]=d3; 0x2D/0x2E/0x2F lim=5/2/1; 0x28 forwarded with up_ch={bank[BW-1:1], d2, d[1:0]} (BW=1: {d2,d[1:0]}); d[1:0]==3 discarded. Others ignored.
- reg >= 0x30: reg[1:0]==3 or reg in 0xB8..0xFF discarded; else forwarded with up_ch={bank, reg[1:0]}, up_op from the latched address-write din[3:2].
- Forward: up_valid set with fields; held stable until up_ready=1 on a clk edge, then cleared that edge.
- clr_flag_A/B: high from pop until next clk_en cycle, then 0.
- busy = queue non-empty | up_valid | data strobe this cycle.
- Prescaler: cnt increments on cen, wraps to 0 at lim; reset cnt=0, lim=5. New lim applies from next cen; cnt > new lim wraps at 7→0.

## Timing
- clk_en registered: high exactly one clk, the cycle after a cen on which cnt==lim (every lim+1 cen pulses).
- Data strobe to queue occupancy: 1 clk. Pop to global output update / up_valid: 1 clk.
- Simultaneous push and pop on full queue: both succeed, no ovf.
- rst mid-operation: queue flushed, up_valid dropped, all outputs to reset values asynchronously.

## Configuration
- JT12_PCM_BYPASS_EN defined: data write with sel_reg==0x2A and sel_bank==0 writes pcm[8:1] one clk after the strobe, is not queued, does not raise busy or ovf, regardless of queue state.
- Undefined: 0x2A is queued and applied at pop like every other global register.

## Test plan
- rst; 6 cen pulses -> clk_en high once, after 6th cen; write 0x2F/any then 2 cen-pulse period -> clk_en every 2 cen.
- Write 0x24=0xAB, 0x25=0x03 -> value_A=0x2AF after two clk_en; busy 1 from first strobe until queue empty.
- DEPTH=4, up_ready=0, addr 0xA0 then 6 data writes with no clk_en -> 4 kept, ovf=1; release -> 4 forwards in order, up_ch=0, up_reg=0xA0.
- CH_BANKS=4, bank 3 address 0x44 (op 1), data 0x7F -> up_ch={3,0}, up_op=1, up_din=0x7F; address 0x43 data -> no forward.
- 0x28 data 0xF6 in bank 1, CH_BANKS=4 -> up_ch={0,1,2}; data 0x03 -> discarded.
- With JT12_PCM_BYPASS_EN, full queue, write 0x2A=0x80 -> pcm=0x100 next clk, ovf unchanged; without -> dropped, ovf=1.
